// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: IO window offsets, core FSM states
// and the STATUS word layout.
package mmio_pkg;

  localparam logic [11:0] OFF_RX     = 12'h000;
  localparam logic [11:0] OFF_TX     = 12'h004;
  localparam logic [11:0] OFF_LED    = 12'h008;
  localparam logic [11:0] OFF_STATUS = 12'h00C;
  localparam logic [11:0] OFF_CYCLE  = 12'h010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_WAIT = 2'd1,
    TX_WAIT = 2'd2
  } state_t;

  function automatic logic [31:0] pack_status(input logic [15:0] rx_cnt,
                                              input logic [7:0]  tx_cnt,
                                              input logic        ovr,
                                              input logic        tx_full,
                                              input logic        rx_empty);
    return {rx_cnt, tx_cnt, 5'b0, ovr, tx_full, rx_empty};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a free-running head (rdata is the entry at the read
// pointer). A pop on empty is ignored; a push on full is accepted only when a
// pop happens in the same cycle, so the count stays unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; data array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Core-to-memory bridge with a 4 KiB IO window holding UART RX/TX FIFOs, an
// LED register and a STATUS word. Core requests (c_load / c_we) are one-cycle
// strobes; the address is held until c_done. RX reads on an empty FIFO and TX
// writes on a full FIFO stall in RX_WAIT / TX_WAIT.
// Optional build macro MMIO_BRIDGE_CYCLE_COUNTER_EN maps a free-running
// 32-bit cycle counter at offset 0x10.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'h10000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          LED_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [31:0]      mem_din,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_we,
  input  logic [31:0]      mem_dout,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  input  logic [31:0]      c_din,
  input  logic [31:0]      c_addr,
  input  logic [3:0]       c_we,
  input  logic             c_load,
  output logic [31:0]      c_dout,
  output logic             c_done,
  output logic [LED_W-1:0] led
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [31:0]   rdata;
  logic [31:0]   io_rdata;
  logic [7:0]    tx_hold;
  logic          overrun;

  logic          io_sel, is_rd, is_wr, io_rd, io_wr;
  logic [11:0]   offset;
  logic          rx_pop, rx_full, rx_empty, overrun_set, status_rd;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    rx_head, tx_wdata;
  logic [CW-1:0] rx_count, tx_count;

  assign io_sel    = (c_addr[31:12] == IO_BASE[31:12]);
  assign offset    = c_addr[11:0];
  assign is_wr     = |c_we;
  assign is_rd     = c_load && !is_wr;
  assign io_rd     = (state == IDLE) && io_sel && is_rd;
  assign io_wr     = (state == IDLE) && io_sel && is_wr;
  assign status_rd = io_rd && (offset == OFF_STATUS);

  assign mem_addr = c_addr;
  assign mem_din  = c_din;
  assign mem_we   = io_sel ? 4'b0 : c_we;
  assign c_dout   = io_sel ? rdata : mem_dout;

  assign rx_pop = rstn && !rx_empty &&
                  ((io_rd && offset == OFF_RX) || state == RX_WAIT);
  assign tx_push = rstn && !tx_full &&
                   ((io_wr && offset == OFF_TX && c_we[0]) || state == TX_WAIT);
  assign tx_wdata      = (state == TX_WAIT) ? tx_hold : c_din[7:0];
  assign uart_tx_valid = !tx_empty;
  assign tx_pop        = uart_tx_valid && uart_tx_ready;
  assign overrun_set   = uart_rx_valid && rx_full && !rx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(uart_rx_valid), .wdata(uart_rx_data),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .wdata(tx_wdata),
    .pop(tx_pop), .rdata(uart_tx_data), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

`ifdef MMIO_BRIDGE_CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!rstn) cyc_cnt <= '0;
    else       cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  // Read mux for the non-blocking IO registers; RX data is handled by the FSM.
  always_comb begin
    io_rdata = '0;
    case (offset)
      OFF_STATUS: io_rdata = pack_status(16'(rx_count), 8'(tx_count),
                                         overrun, tx_full, rx_empty);
      OFF_LED:    io_rdata = 32'(led);
`ifdef MMIO_BRIDGE_CYCLE_COUNTER_EN
      OFF_CYCLE:  io_rdata = cyc_cnt;
`endif
      default:    io_rdata = '0;
    endcase
  end

  // Core access FSM: completes accesses and stalls on empty RX / full TX.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      c_done <= 1'b0;
      rdata  <= '0;
    end else begin
      c_done <= 1'b0;
      case (state)
        IDLE: begin
          if (io_sel && is_rd) begin
            if (offset == OFF_RX) begin
              if (rx_empty) begin
                state <= RX_WAIT;
              end else begin
                rdata  <= {24'b0, rx_head};
                c_done <= 1'b1;
              end
            end else begin
              rdata  <= io_rdata;
              c_done <= 1'b1;
            end
          end else if (io_sel && is_wr) begin
            if (offset == OFF_TX && c_we[0] && tx_full) state  <= TX_WAIT;
            else                                        c_done <= 1'b1;
          end else if (is_rd || is_wr) begin
            c_done <= 1'b1;
          end
        end
        RX_WAIT: begin
          if (!rx_empty) begin
            rdata  <= {24'b0, rx_head};
            c_done <= 1'b1;
            state  <= IDLE;
          end
        end
        TX_WAIT: begin
          if (!tx_full) begin
            c_done <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the TX byte so a stalled write no longer needs c_din held.
  always_ff @(posedge clk) begin
    if (io_wr && offset == OFF_TX) tx_hold <= c_din[7:0];
  end

  // LED register and sticky overrun flag; a new overrun beats a STATUS clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      led     <= '0;
      overrun <= 1'b0;
    end else begin
      if (io_wr && offset == OFF_LED) led <= c_din[LED_W-1:0];
      if (overrun_set)    overrun <= 1'b1;
      else if (status_rd) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: table-driven register/memory accesses
// plus hand-written sequences for stalls, overrun and reset mid-access.
module tb_mmio_bridge;
  import mmio_pkg::*;

  localparam logic [31:0] IOB = 32'h10000;

  logic        clk, rstn;
  logic [31:0] mem_din, mem_addr, mem_dout;
  logic [3:0]  mem_we;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid;
  logic [31:0] c_din, c_addr, c_dout;
  logic [3:0]  c_we;
  logic        c_load, c_done;
  logic [7:0]  led;

  mmio_bridge #(.IO_BASE(IOB), .FIFO_DEPTH(16), .LED_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .c_din(c_din), .c_addr(c_addr), .c_we(c_we), .c_load(c_load),
    .c_dout(c_dout), .c_done(c_done), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];

  // Small byte-addressable memory behind the bridge.
  logic [31:0] tbmem [16];
  initial for (int i = 0; i < 16; i++) tbmem[i] = '0;
  assign mem_dout = tbmem[mem_addr[5:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we[b]) tbmem[mem_addr[5:2]][8*b +: 8] <= mem_din[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // TX scoreboard: every handshake must match the oldest expected byte.
  always @(negedge clk) begin
    if (rstn && uart_tx_valid && uart_tx_ready) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got byte 0x%02h, expected none", uart_tx_data);
      end else begin
        chk("tx_data", {24'b0, uart_tx_data}, {24'b0, tx_q.pop_front()});
      end
    end
  end

  task automatic access(input logic [3:0] we, input logic ld, input logic [31:0] addr,
                        input logic [31:0] wd, input int budget, output int lat);
    @(posedge clk); #1;
    c_addr = addr; c_din = wd; c_we = we; c_load = ld;
    @(posedge clk); #1;
    c_we = '0; c_load = 1'b0;
    lat = 0;
    while (!c_done && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!c_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL access_timeout 0x%08h: c_done=0 after %0d cycles, expected 1", addr, lat);
      if (ld && exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (ld) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_noexp 0x%08h: got 0x%08h, expected no read", addr, c_dout);
      end else begin
        chk($sformatf("rd_%08h", addr), c_dout, exp_q.pop_front());
      end
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, output int lat);
    exp_q.push_back(exp);
    access(4'h0, 1'b1, addr, 32'h0, 60, lat);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge clk); #1;
    uart_rx_data = b; uart_rx_valid = 1'b1;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  we;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, lat2;

    vecs.push_back('{4'hF, 1'b0, IOB + 32'h8,  32'h0000_00A5, 32'h0});
    vecs.push_back('{4'h0, 1'b1, IOB + 32'h8,  32'h0,         32'h0000_00A5});
    vecs.push_back('{4'h0, 1'b1, IOB + 32'hC,  32'h0,         32'h0000_0001});
    vecs.push_back('{4'h0, 1'b1, IOB + 32'h14, 32'h0,         32'h0});
    vecs.push_back('{4'hF, 1'b0, IOB + 32'h20, 32'hDEAD_BEEF, 32'h0});
    vecs.push_back('{4'h0, 1'b1, IOB + 32'h20, 32'h0,         32'h0});
    vecs.push_back('{4'h0, 1'b1, IOB + 32'h8,  32'h0,         32'h0000_00A5});
    vecs.push_back('{4'hF, 1'b0, 32'h100,      32'h1234_5678, 32'h0});
    vecs.push_back('{4'h0, 1'b1, 32'h100,      32'h0,         32'h1234_5678});
    vecs.push_back('{4'h1, 1'b0, 32'h104,      32'hFFFF_FFEE, 32'h0});
    vecs.push_back('{4'hC, 1'b0, 32'h104,      32'hAABB_CCDD, 32'h0});
    vecs.push_back('{4'h0, 1'b1, 32'h104,      32'h0,         32'hAABB_00EE});
`ifndef MMIO_BRIDGE_CYCLE_COUNTER_EN
    vecs.push_back('{4'h0, 1'b1, IOB + 32'h10, 32'h0,         32'h0});
`endif

    rstn = 1'b0; c_addr = IOB; c_din = '0; c_we = '0; c_load = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c_done", {31'b0, c_done}, 32'h0);
    chk("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    chk("rst_led", {24'b0, led}, 32'h0);
    chk("rst_c_dout", c_dout, 32'h0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rstn = 1'b1;

    // Register and pass-through table.
    foreach (vecs[i]) begin
      if (vecs[i].ld) exp_q.push_back(vecs[i].exp);
      access(vecs[i].we, vecs[i].ld, vecs[i].addr, vecs[i].wd, 20, lat);
      chk($sformatf("vec%0d_lat", i), lat, 0);
    end

    // LED write: memory must not see a write; non-IO write passes through.
    @(posedge clk); #1;
    c_addr = IOB + 32'h8; c_din = 32'h0000_003C; c_we = 4'hF;
    #1;
    chk("led_mem_we", {28'b0, mem_we}, 32'h0);
    @(posedge clk); #1;
    c_we = '0;
    chk("led_done", {31'b0, c_done}, 32'h1);
    chk("led_val", {24'b0, led}, 32'h3C);
    c_addr = 32'h100; c_din = 32'h1234_5678; c_we = 4'hF;
    #1;
    chk("pt_we", {28'b0, mem_we}, 32'hF);
    chk("pt_addr", mem_addr, 32'h100);
    chk("pt_din", mem_din, 32'h1234_5678);
    @(posedge clk); #1;
    c_we = '0;
    chk("pt_done", {31'b0, c_done}, 32'h1);

    // TX path with the transmitter ready.
    uart_tx_ready = 1'b1;
    tx_q.push_back(8'h41);
    access(4'h1, 1'b0, IOB + 32'h4, 32'h41, 20, lat);
    chk("tx41_lat", lat, 0);
    tx_q.push_back(8'h42);
    access(4'h1, 1'b0, IOB + 32'h4, 32'h42, 20, lat);
    chk("tx42_lat", lat, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("tx_drained", tx_q.size(), 0);
    chk("tx_idle", {31'b0, uart_tx_valid}, 32'h0);

    // RX read that waits for a byte arriving later.
    fork
      rd(IOB, 32'h0000_005A, lat);
      begin
        repeat (10) @(posedge clk);
        rx_pulse(8'h5A);
      end
    join
    chk("rxwait_lat_ge9", {31'b0, (lat >= 9)}, 32'h1);

    // Overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) rx_pulse(8'h80 + 8'(i));
    rd(IOB + 32'hC, 32'h0010_0004, lat);
    rd(IOB + 32'hC, 32'h0010_0000, lat);

    // Pop and push on a full RX FIFO in the same cycle.
    exp_q.push_back(32'h80);
    @(posedge clk); #1;
    c_addr = IOB; c_load = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h99;
    @(posedge clk); #1;
    c_load = 1'b0; uart_rx_valid = 1'b0;
    chk("fullpp_done", {31'b0, c_done}, 32'h1);
    chk("fullpp_data", c_dout, exp_q.pop_front());
    rd(IOB + 32'hC, 32'h0010_0000, lat);
    for (int i = 1; i < 16; i++) rd(IOB, 32'h80 + 32'(i), lat);
    rd(IOB, 32'h99, lat);
    rd(IOB + 32'hC, 32'h0000_0001, lat);

    // TX stall: 16 writes fill the FIFO, the 17th waits for the transmitter.
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'h60 + 8'(i));
      access(4'h1, 1'b0, IOB + 32'h4, 32'h60 + 32'(i), 20, lat);
      chk("txfill_lat", lat, 0);
    end
    rd(IOB + 32'hC, 32'h0000_1003, lat);
    tx_q.push_back(8'h70);
    fork
      access(4'h1, 1'b0, IOB + 32'h4, 32'h70, 60, lat2);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("txwait_state", 32'(dut.state), 32'(TX_WAIT));
        chk("txwait_done", {31'b0, c_done}, 32'h0);
        uart_tx_ready = 1'b1;
      end
    join
    chk("txwait_lat_ge4", {31'b0, (lat2 >= 4)}, 32'h1);
    repeat (25) @(posedge clk);
    #1;
    chk("txstall_drained", tx_q.size(), 0);

    // Reset while stalled in RX_WAIT, with a byte pending in TX.
    uart_tx_ready = 1'b0;
    access(4'h1, 1'b0, IOB + 32'h4, 32'hEE, 20, lat);
    @(posedge clk); #1;
    c_addr = IOB; c_load = 1'b1;
    @(posedge clk); #1;
    c_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rxw_state", 32'(dut.state), 32'(RX_WAIT));
    chk("rxw_done", {31'b0, c_done}, 32'h0);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rxw_rst_state", 32'(dut.state), 32'(IDLE));
    chk("rxw_rst_done", {31'b0, c_done}, 32'h0);
    chk("rxw_rst_txv", {31'b0, uart_tx_valid}, 32'h0);
    rstn = 1'b1;
    rd(IOB + 32'hC, 32'h0000_0001, lat);
    uart_tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_tx_idle", {31'b0, uart_tx_valid}, 32'h0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
